// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state encoding, port
// identifiers and the widths of the latency and starvation counters.
// Ports: none (package).
// Configuration: MEM_PORT_ARBITER_RR_EN selects round-robin arbitration in
// the modules that import this package.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Smallest width able to hold max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

    // Counters are sized for the largest legal MEM_LATENCY (7) and
    // STARVE_LIMIT (15) so any legal parameter value fits.
    localparam int LAT_MAX    = 7;
    localparam int STARVE_MAX = 15;
    localparam int LAT_W      = cnt_width(LAT_MAX);
    localparam int STARVE_W   = cnt_width(STARVE_MAX);

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection between the cpu and aux requesters.
// Ports:
//   cpu_req, aux_req : pending requests
//   starve_cnt       : lost-tie count for aux (fixed-priority build)
//   last_grant       : port granted last (round-robin build)
//   winner           : selected port (PORT_CPU / PORT_AUX)
// Configuration: MEM_PORT_ARBITER_RR_EN swaps fixed priority with starvation
// guard for round-robin tie breaking.
// -----------------------------------------------------------------------------
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                cpu_req,
    input  logic                aux_req,
`ifdef MEM_PORT_ARBITER_RR_EN
    input  logic                last_grant,
`else
    input  logic [STARVE_W-1:0] starve_cnt,
`endif
    output logic                winner
);

    // A lone requester always wins; only a tie needs a policy.
    always_comb begin
        winner = PORT_CPU;
        if (cpu_req && aux_req) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            winner = ~last_grant;
`else
            winner = (starve_cnt >= STARVE_W'(STARVE_LIMIT)) ? PORT_AUX : PORT_CPU;
`endif
        end else if (aux_req) begin
            winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-port memory between the cpu datapath and an aux
// (loader/debug) port. One transaction at a time: IDLE picks a winner and
// latches its command, ACCESS holds the memory controls for MEM_LATENCY
// cycles and captures read data on the last one, DONE pulses the ack.
// Ports:
//   clock, reset_n                          : clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata    : cpu requester
//   aux_req/we/addr/wdata, aux_ack/rdata    : aux requester
//   mem_re, mem_we, mem_addr, mem_wdata     : memory controls
//   mem_rdata                               : memory read data
//   grant                                   : owner of current transaction
//   busy                                    : high outside IDLE
// Configuration: define MEM_PORT_ARBITER_RR_EN for round-robin tie breaking
// instead of cpu priority with an aux starvation guard.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic              busy
);

    state_t              state;
    state_t              state_next;
    logic [LAT_W-1:0]    lat_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                winner;
    logic                any_req;
    logic                last_access;

    assign any_req     = cpu_req | aux_req;
    assign last_access = (lat_cnt == LAT_W'(1));

`ifdef MEM_PORT_ARBITER_RR_EN
    logic last_grant;

    arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .cpu_req    (cpu_req),
        .aux_req    (aux_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Resets to aux so the very first tie goes to cpu.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT_AUX;
        end else if (state == ST_IDLE && any_req) begin
            last_grant <= winner;
        end
    end
`else
    logic [STARVE_W-1:0] starve_cnt;

    arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .cpu_req    (cpu_req),
        .aux_req    (aux_req),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    // Counts ties aux has lost; saturates at the limit, which is exactly when
    // aux wins the next tie and the count clears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE && any_req) begin
            if (winner == PORT_AUX) begin
                starve_cnt <= '0;
            end else if (aux_req && starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction registers: the command is frozen in IDLE so requester
    // inputs may change freely while the access runs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            grant     <= PORT_CPU;
            cpu_rdata <= '0;
            aux_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant     <= winner;
                        lat_cnt   <= LAT_W'(MEM_LATENCY);
                        lat_we    <= (winner == PORT_AUX) ? aux_we    : cpu_we;
                        lat_addr  <= (winner == PORT_AUX) ? aux_addr  : cpu_addr;
                        lat_wdata <= (winner == PORT_AUX) ? aux_wdata : cpu_wdata;
                    end
                end
                ST_ACCESS: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (last_access && !lat_we) begin
                        if (grant == PORT_AUX) begin
                            aux_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs decode purely from state and latched command,
    // so an asynchronous reset drops the strobes immediately.
    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_ack    = 1'b0;
        aux_ack    = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_req) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_re    = ~lat_we;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                if (last_access) state_next = ST_DONE;
            end
            ST_DONE: begin
                cpu_ack    = (grant == PORT_CPU);
                aux_ack    = (grant == PORT_AUX);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The main instance (MEM_LATENCY=1) is
// checked by a scoreboard: stimulus pushes the expected ack owner and both
// rdata values, a monitor pops and compares on every ack. A second instance
// (MEM_LATENCY=3) shares the inputs and is checked cycle by cycle for the
// dropped-request case. Memory is a combinational function of address.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        port;
        logic [15:0] cpu_rd;
        logic [15:0] aux_rd;
    } sb_entry_t;

    logic        clock;
    logic        reset_n;
    logic        cpu_req, cpu_we, aux_req, aux_we;
    logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;

    logic        cpu_ack, aux_ack, mem_re, mem_we, grant, busy;
    logic [15:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        cpu_ack3, aux_ack3, mem_re3, mem_we3, grant3, busy3;
    logic [15:0] cpu_rdata3, aux_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    sb_entry_t   sb[$];
    sb_entry_t   mon_e;
    int          compared;
    int          mismatched;
    logic [15:0] exp_cpu;
    logic [15:0] exp_aux;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    assign mem_rdata  = mem_model(mem_addr);
    assign mem_rdata3 = mem_model(mem_addr3);

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack3), .aux_rdata(aux_rdata3),
        .mem_re(mem_re3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .grant(grant3), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest expected entry.
    always @(posedge clock) begin
        #1;
        if (cpu_ack || aux_ack) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ack: got cpu_ack=%b aux_ack=%b, expected none", cpu_ack, aux_ack);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_both_acks", {31'b0, cpu_ack & aux_ack}, 32'd0);
                checkOutput("sb_ack_port", {31'b0, aux_ack}, {31'b0, mon_e.port});
                checkOutput("sb_grant", {31'b0, grant}, {31'b0, mon_e.port});
                checkOutput("sb_cpu_rdata", {16'b0, cpu_rdata}, {16'b0, mon_e.cpu_rd});
                checkOutput("sb_aux_rdata", {16'b0, aux_rdata}, {16'b0, mon_e.aux_rd});
            end
        end
    end

    task automatic pushExpect(input logic port);
        sb_entry_t e;
        e.port   = port;
        e.cpu_rd = exp_cpu;
        e.aux_rd = exp_aux;
        sb.push_back(e);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clock);
        while ((busy || busy3) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (busy || busy3) checkOutput("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulseReset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_cpu = 16'h0000;
        exp_aux = 16'h0000;
    endtask

    // Single transaction on the idle main instance: checks the memory
    // controls in the access cycle, ack latency and return to IDLE.
    task automatic applyStimulus(input string tname, input logic port, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        int  cyc;
        bit  got;
        @(negedge clock);
        if (port) begin
            aux_req = 1'b1; aux_we = we; aux_addr = addr; aux_wdata = wdata;
            if (!we) exp_aux = mem_model(addr);
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            if (!we) exp_cpu = mem_model(addr);
        end
        pushExpect(port);
        @(posedge clock);
        #1;
        checkOutput({tname, "_mem_re"}, {31'b0, mem_re}, {31'b0, ~we});
        checkOutput({tname, "_mem_we"}, {31'b0, mem_we}, {31'b0, we});
        checkOutput({tname, "_mem_addr"}, {16'b0, mem_addr}, {16'b0, addr});
        if (we) checkOutput({tname, "_mem_wdata"}, {16'b0, mem_wdata}, {16'b0, wdata});
        checkOutput({tname, "_grant"}, {31'b0, grant}, {31'b0, port});
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (port ? aux_ack : cpu_ack) got = 1;
        end
        checkOutput({tname, "_ack_seen"}, {31'b0, got}, 32'd1);
        checkOutput({tname, "_ack_cycle"}, cyc, 32'd2);
        cpu_req = 1'b0;
        aux_req = 1'b0;
        @(negedge clock);
        checkOutput({tname, "_idle_after"}, {31'b0, busy}, 32'd0);
        checkOutput({tname, "_mem_re_idle"}, {31'b0, mem_re | mem_we}, 32'd0);
    endtask

    initial begin
        int  acks;
        int  n;
        logic exp_port;
        compared   = 0;
        mismatched = 0;
        exp_cpu    = 16'h0000;
        exp_aux    = 16'h0000;
        reset_n    = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = 16'h0; aux_wdata = 16'h0;
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_strobes", {30'b0, mem_re, mem_we}, 32'd0);
        checkOutput("reset_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
        checkOutput("reset_acks", {30'b0, cpu_ack, aux_ack}, 32'd0);
        reset_n = 1'b1;

        $display("[TB] cpu read of 0x0010");
        waitIdle();
        applyStimulus("cpu_rd", 1'b0, 1'b0, 16'h0010, 16'h0000);

        $display("[TB] aux write 0x1234 to 0x0020");
        waitIdle();
        applyStimulus("aux_wr", 1'b1, 1'b1, 16'h0020, 16'h1234);

        $display("[TB] reset during cpu access");
        waitIdle();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        @(posedge clock);
        #1;
        checkOutput("rst_mid_re_before", {31'b0, mem_re}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_re_async", {31'b0, mem_re}, 32'd0);
        checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
        cpu_req = 1'b0;
        exp_cpu = 16'h0000;
        exp_aux = 16'h0000;
        @(negedge clock);
        checkOutput("rst_mid_cpu_rdata", {16'b0, cpu_rdata}, 32'd0);
        reset_n = 1'b1;
        applyStimulus("rst_fresh_rd", 1'b0, 1'b0, 16'h0011, 16'h0000);

        $display("[TB] cpu write leaves cpu_rdata alone");
        waitIdle();
        applyStimulus("cpu_wr", 1'b0, 1'b1, 16'h0060, 16'hCAFE);

        $display("[TB] cpu drops request during access, latency 3 instance");
        waitIdle();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
        exp_cpu = mem_model(16'h0050);
        pushExpect(1'b0);
        @(negedge clock);
        cpu_req  = 1'b0;
        cpu_addr = 16'hFFFF;
        checkOutput("drop_c1_re3", {31'b0, mem_re3}, 32'd1);
        checkOutput("drop_c1_addr3", {16'b0, mem_addr3}, 32'h0050);
        @(negedge clock);
        checkOutput("drop_c2_re3", {31'b0, mem_re3}, 32'd1);
        checkOutput("drop_c2_ack3", {31'b0, cpu_ack3}, 32'd0);
        @(negedge clock);
        checkOutput("drop_c3_re3", {31'b0, mem_re3}, 32'd1);
        checkOutput("drop_c3_addr3", {16'b0, mem_addr3}, 32'h0050);
        @(negedge clock);
        checkOutput("drop_c4_ack3", {31'b0, cpu_ack3}, 32'd1);
        checkOutput("drop_c4_re3", {31'b0, mem_re3}, 32'd0);
        checkOutput("drop_c4_rdata3", {16'b0, cpu_rdata3}, {16'b0, mem_model(16'h0050)});
        @(negedge clock);
        checkOutput("drop_c5_busy3", {31'b0, busy3}, 32'd0);
        checkOutput("drop_c5_ack3", {31'b0, cpu_ack3}, 32'd0);

        $display("[TB] both requesters held");
        waitIdle();
        pulseReset();
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0040;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            exp_port = (i % 2 == 1);
`else
            exp_port = (i % 5 == 4);
`endif
            if (exp_port) exp_aux = mem_model(16'h0040);
            else          exp_cpu = mem_model(16'h0030);
            pushExpect(exp_port);
        end
        acks = 0;
        n    = 0;
        while (acks < 10 && n < 100) begin
            @(negedge clock);
            n++;
            if (cpu_ack || aux_ack) acks++;
        end
        checkOutput("both_ack_count", acks, 32'd10);
        cpu_req = 1'b0;
        aux_req = 1'b0;

        waitIdle();
        repeat (2) @(negedge clock);
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit unified Memory between two requesters.
  - Port 0 (cpu): the multicycle datapath's fetch/load/store path.
  - Port 1 (aux): a program loader / debug port.
- Sits between the requesters and Memory.
- Serialises accesses with a small FSM and returns read data plus a one-cycle ack per transaction.
- Fixed priority favours cpu, with a starvation guard for aux.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, data word width.
- MEM_LATENCY, 1, cycles memory controls are held before read data is sampled (1..7).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which aux wins (1..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  cpu request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  cpu address.
- cpu_wdata  input  DATA_W  cpu write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  read data, valid when cpu_ack=1.
- aux_req, aux_we, aux_addr, aux_wdata  input  1/1/ADDR_W/DATA_W  same as cpu_*.
- aux_ack, aux_rdata  output  1/DATA_W  same as cpu_*.
- mem_re  output  1  memory read strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- grant  output  1  owner of the current transaction: 0 = cpu, 1 = aux.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs 0; rdata registers 0; starve counter 0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Sample requests.
  - If any request is pending: choose a winner, latch its we/addr/wdata into internal registers, set grant, load the latency counter with MEM_LATENCY, and go to ACCESS.
  - No request: remain in IDLE; mem_* outputs stay 0.
- ACCESS:
  - mem_addr/mem_wdata come from the latched registers.
  - mem_re = !we and mem_we = we, held for every ACCESS cycle.
  - Counter decrements each cycle.
  - On the final cycle (counter=1), mem_rdata is captured into the winner's rdata register at the clock edge; FSM goes to DONE.
- DONE:
  - Winner's ack = 1 for exactly one cycle; mem strobes are 0.
  - Requests are not sampled; FSM returns to IDLE.
- Latency: request seen in IDLE at cycle 0 -> ack in cycle MEM_LATENCY+1. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Arbitration rules:
  - Only cpu requests: cpu wins.
  - Only aux requests: aux wins.
  - Both request, starve_cnt < STARVE_LIMIT: cpu wins and starve_cnt increments.
  - Both request, starve_cnt = STARVE_LIMIT: aux wins.
  - Any aux grant clears starve_cnt.
  - starve_cnt saturates and never wraps.
- Request inputs are sampled only in IDLE.
  - If req is dropped or inputs change during ACCESS, the latched transaction still completes and ack is still issued.
  - A requester keeping req high after its ack is treated as a new request at the next IDLE.
- Write transactions:
  - rdata of the winner is left unchanged.
  - ack is still pulsed.
- rdata of the non-winning port is never modified.
- Reset mid-transaction: access is aborted, strobes drop immediately, no ack is issued.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the port not granted last wins. A last_grant flop resets to 1, so cpu wins the first tie. starve_cnt logic is removed.
- Undefined: fixed priority with starvation guard, as described above.

Decomposition:
- Package mem_arb_pkg:
  - FSM state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10).
  - Port ID constants PORT_CPU=1'b0, PORT_AUX=1'b1.
  - Counter widths derived from MEM_LATENCY and STARVE_LIMIT.
- One sub-module, arb_pick:
  - Combinational winner selection from cpu_req, aux_req, starve_cnt/last_grant.
  - Swaps cleanly under MEM_PORT_ARBITER_RR_EN.

Test Plan:
1. Reset mid-ACCESS: cpu read in flight, pulse reset_n low -> mem_re drops to 0 asynchronously, no cpu_ack, busy=0, then a fresh read completes normally.
2. cpu read, MEM_LATENCY=1, mem returns 16'hBEEF for addr 16'h0010 -> mem_re=1 in cycle 1, cpu_ack=1 with cpu_rdata=16'hBEEF in cycle 2, FSM back in IDLE in cycle 3.
3. aux write addr 16'h0020 data 16'h1234, cpu idle -> mem_we=1 with that addr/data for MEM_LATENCY cycles, grant=1, aux_ack pulse, cpu_rdata unchanged.
4. Both requesters held continuously, STARVE_LIMIT=4 -> grant sequence cpu,cpu,cpu,cpu,aux,cpu,... with acks matching grant.
5. cpu drops cpu_req in the first ACCESS cycle, MEM_LATENCY=3 -> access still runs 3 cycles, cpu_ack issued at cycle 4.
6. With MEM_PORT_ARBITER_RR_EN, both requesters held -> grants alternate cpu,aux,cpu,aux starting with cpu.
